inst_fetch_stage: RTL

INST_FETCH_STAGE -- requirements
Module: inst_fetch_stage

---
 rtl/inst_fetch_stage.sv | 105 ++++++++++
 1 files changed

// File: rtl/inst_fetch_stage.sv
// Instruction fetch stage: drives a synchronous instruction RAM, presents one
// instruction per cycle with a one-entry skid so stalls never drop a response.
module inst_fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'h1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_pc,
  output logic        imem_rd_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  output logic [15:0] pc,
  output logic [15:0] inst,
  output logic        inst_valid,
  output logic        halted
);

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] inst;
  } fetch_ent_t;

  logic [15:0] fetch_pc;
  logic        rsp_vld;
  logic [15:0] rsp_pc;
  fetch_ent_t  out_q, out_n, skid_q, skid_n, cap_ent;
  logic        out_vld, out_vld_n, skid_vld, skid_vld_n;
  logic        halted_q, halted_n;
  logic        issue, cap, out_free;

  // Issue is held off while a stalled output and an in-flight response would
  // leave the skid as the only landing spot for a further response.
  assign issue = !rst && !halted_q && !branch_taken && !skid_vld &&
                 !(stall && rsp_vld && out_vld);

  assign cap      = rsp_vld && !branch_taken && !halted_q;
  assign cap_ent  = '{pc: rsp_pc, inst: imem_data};
  assign out_free = !out_vld || !stall;

  always_comb begin
    out_n      = out_q;
    out_vld_n  = out_vld;
    skid_n     = skid_q;
    skid_vld_n = skid_vld;
    if (out_free) begin
      if (skid_vld) begin
        out_n      = skid_q;
        out_vld_n  = 1'b1;
        skid_vld_n = 1'b0;
        if (cap) begin
          skid_n     = cap_ent;
          skid_vld_n = 1'b1;
        end
      end else if (cap) begin
        out_n     = cap_ent;
        out_vld_n = 1'b1;
      end else begin
        out_vld_n = 1'b0;
      end
    end else if (cap) begin
      skid_n     = cap_ent;
      skid_vld_n = 1'b1;
    end
    halted_n = halted_q || (cap && (imem_data[15:12] == HALT_OPCODE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      rsp_vld  <= 1'b0;
      rsp_pc   <= '0;
      out_q    <= '0;
      out_vld  <= 1'b0;
      skid_q   <= '0;
      skid_vld <= 1'b0;
      halted_q <= 1'b0;
    end else if (branch_taken) begin
      fetch_pc <= branch_pc;
      rsp_vld  <= 1'b0;
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + 16'h0001;
      rsp_vld  <= issue;
      rsp_pc   <= fetch_pc;
      out_q    <= out_n;
      out_vld  <= out_vld_n;
      skid_q   <= skid_n;
      skid_vld <= skid_vld_n;
      halted_q <= halted_n;
    end
  end

  assign imem_rd_en = issue;
  assign imem_addr  = fetch_pc;
  assign pc         = out_q.pc;
  assign inst       = out_q.inst;
  assign inst_valid = out_vld;
  assign halted     = halted_q;

endmodule
